decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised instruction-decode stage of the pipelined RISC-V core, placed between the IF/ID register and the execute stage. It holds the architectural register file with write-back bypass, decodes the opcode into execute/memory/write-back controls, generates sign-extended immediates for all base formats, detects load-use hazards, and registers everything into an ID/EX pipeline register with stall and flush handling. It generalises the original combinational decode in three ways: data width and register count are parametrised, the stage now owns its ID/EX register, and it adds hazard detection, bubble insertion and illegal-instruction flagging.

## Interface
- XLEN, 64, data/address width (32 or 64)
- NREG, 32, architectural registers (32 for RV-I, 16 for RV-E); index width RW = clog2(NREG)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- ix  in  32  instruction
- pc_in  in  XLEN  PC of ix
- flush  in  1  redirect from execute; squash the instruction in decode
- wb_we  in  1  write-back enable
- wb_wa  in  5  write-back register index
- wb_wd  in  XLEN  write-back data
- stall  out  1  hold IF/ID and PC (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- regWrite, memToReg, branch, jump, memRead, memWrite, aluSrc  out  1 each  registered controls
- aluOp  out  2  registered ALU class
- rd1, rd2, imm, pc  out  XLEN each  registered operands, immediate, PC
- funct7_5  out  1; funct3  out  3; wa, rs1, rs2  out  5 each  registered fields
- illegal  out  1  registered unknown-opcode / out-of-range register flag

## Operation
- Register file: NREG x XLEN. Writes happen on the clock edge when wb_we=1, wb_wa!=0 and wb_wa<NREG. x0 always reads 0.
- Read bypass: if wb_we=1, wb_wa==rsN, and rsN!=0, then rdN=wb_wd in the same cycle.
- Decode by opcode (ix[6:0]). aluOp: 00 add, 01 branch compare, 10 R-type, 11 I-ALU.
  - R 0110011: regWrite, aluOp=10.
  - I-ALU 0010011: regWrite, aluSrc, aluOp=11.
  - LOAD 0000011: regWrite, memRead, memToReg, aluSrc, aluOp=00.
  - STORE 0100011: memWrite, aluSrc, aluOp=00.
  - BRANCH 1100011: branch, aluOp=01.
  - JAL 1101111: regWrite, jump, aluOp=00.
  - JALR 1100111: regWrite, jump, aluSrc, aluOp=00.
  - LUI 0110111 and AUIPC 0010111: regWrite, aluSrc, aluOp=00.
  - Any other opcode: all controls 0, illegal=1.
- Out-of-range register index: for NREG=16, any used rs1, rs2 or rd with bit 4 set also sets illegal=1 and forces all controls to 0.
- Immediates are sign-extended from ix[31] to XLEN:
  - I-type: ix[31:20].
  - S-type: {ix[31:25], ix[11:7]}.
  - B-type: {ix[31], ix[7], ix[30:25], ix[11:8], 0}.
  - U-type: {ix[31:12], 12'b0}.
  - J-type: {ix[31], ix[19:12], ix[20], ix[30:21], 0}.
  - R-type: imm=0.
- Register use: rs1 is used by every format except U and J. rs2 is used only by R, S and B.
- Load-use hazard: stall=1 when all of the following hold:
  - if_valid=1 and flush=0;
  - ex_valid=1, memRead=1 and wa!=0;
  - wa equals a used rs1 or a used rs2.
- ID/EX update each cycle, in priority order:
  - rst=0: reset values (below).
  - flush=1: bubble.
  - stall=1: bubble; IF/ID holds externally.
  - if_valid=0: bubble.
  - Otherwise: load the decoded instruction with ex_valid=1.
- A bubble sets ex_valid=0 and every control and illegal to 0. Data fields may update and are don't-care.

## Timing
- Latency: ix presented in cycle N appears on the ID/EX outputs after the rising edge ending cycle N.
- Reset (rst=0 at an edge): every registered output is 0, including ex_valid, all controls, rd1/rd2/imm/pc and all fields. All NREG registers are cleared to 0. stall=0 while ex_valid=0.
- Reset asserted mid-stall: the next edge clears the state and stall drops.
- A stall lasts exactly one cycle per load-use pair: the bubble clears ex_valid, which releases the stall in the following cycle.
- flush and stall in the same cycle: flush wins, stall=0, bubble inserted.
- Write-back to a source register in the same cycle as decode: the bypassed value is captured into rd1/rd2.
- wb_wa=0 never modifies state, and a bypass on index 0 is suppressed.

## Test plan
- Reset, then write x5=0x1234 via write-back, then decode `add x1,x5,x5` -> after 1 cycle rd1=rd2=0x1234, aluOp=10, regWrite=1, ex_valid=1.
- `lw x3,-4(x2)` followed by `add x4,x3,x1` -> stall=1 for one cycle, a bubble with ex_valid=0, then add issues with wa=4 and rs1=3.
- Same-cycle write-back wb_wa=7, wb_wd=0xFFFF_0000 while decoding `sw x7,8(x0)` -> rd2=0xFFFF_0000, imm=8, memWrite=1.
- Immediates at XLEN=64: `beq` with offset -2 gives imm=0xFFFF_FFFF_FFFF_FFFE; `lui x1,0x80000` gives imm=0xFFFF_FFFF_8000_0000. Repeat at XLEN=32: 0xFFFF_FFFE and 0x8000_0000.
- flush asserted during a load-use stall -> stall=0, ex_valid=0 on the next edge. Opcode 0x7F -> illegal=1 with all controls 0.
- NREG=16: `add x17,x1,x2` -> illegal=1, regWrite=0. Write-back to x0 with data 0xAA -> x0 still reads 0.

Source files
------------

// File: rtl/decode_stage.sv
// RISC-V decode stage: register file with write-back bypass, control decode,
// immediate generation, load-use hazard detection and the ID/EX register.
module decode_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     ix,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    output logic            stall,
    output logic            ex_valid,
    output logic            regWrite,
    output logic            memToReg,
    output logic            branch,
    output logic            jump,
    output logic            memRead,
    output logic            memWrite,
    output logic            aluSrc,
    output logic [1:0]      aluOp,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc,
    output logic            funct7_5,
    output logic [2:0]      funct3,
    output logic [4:0]      wa,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            illegal
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic idx_bad(input logic [4:0] idx);
        return {27'b0, idx} >= 32'(NREG);
    endfunction

    logic [XLEN-1:0] regs_reg [NREG];
    logic            wb_write;
    logic [4:0]      rs_idx [2];
    logic [XLEN-1:0] rs_val [2];

    assign wb_write  = wb_we && (wb_wa != 5'd0) && !idx_bad(wb_wa);
    assign rs_idx[0] = ix[19:15];
    assign rs_idx[1] = ix[24:20];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_write) begin
            regs_reg[wb_wa[RW-1:0]] <= wb_wd;
        end
    end

    // Same-cycle write-back wins over the stored value; x0 is hardwired.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            assign rs_val[gi] = (rs_idx[gi] == 5'd0) ? '0 :
                                (wb_we && wb_wa == rs_idx[gi]) ? wb_wd :
                                regs_reg[rs_idx[gi][RW-1:0]];
        end
    endgenerate

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = XLEN'($signed(ix[31:20]));
    assign imm_s = XLEN'($signed({ix[31:25], ix[11:7]}));
    assign imm_b = XLEN'($signed({ix[31], ix[7], ix[30:25], ix[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ix[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({ix[31], ix[19:12], ix[20], ix[30:21], 1'b0}));

    logic            reg_write_d, mem_to_reg_d, branch_d, jump_d;
    logic            mem_read_d, mem_write_d, alu_src_d, known_op;
    logic            use_rs1, use_rs2, use_rd;
    logic [1:0]      alu_op_d;
    logic [XLEN-1:0] imm_d;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        alu_op_d     = 2'b00;
        known_op     = 1'b1;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        use_rd       = 1'b0;
        imm_d        = '0;
        case (ix[6:0])
            OP_R: begin
                reg_write_d = 1'b1; alu_op_d = 2'b10;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            OP_IMM: begin
                reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = 2'b11;
                use_rs1 = 1'b1; use_rd = 1'b1; imm_d = imm_i;
            end
            OP_LOAD: begin
                reg_write_d = 1'b1; mem_read_d = 1'b1; mem_to_reg_d = 1'b1;
                alu_src_d = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1; imm_d = imm_i;
            end
            OP_STORE: begin
                mem_write_d = 1'b1; alu_src_d = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm_d = imm_s;
            end
            OP_BRANCH: begin
                branch_d = 1'b1; alu_op_d = 2'b01;
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm_d = imm_b;
            end
            OP_JAL: begin
                reg_write_d = 1'b1; jump_d = 1'b1; use_rd = 1'b1; imm_d = imm_j;
            end
            OP_JALR: begin
                reg_write_d = 1'b1; jump_d = 1'b1; alu_src_d = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1; imm_d = imm_i;
            end
            OP_LUI, OP_AUIPC: begin
                reg_write_d = 1'b1; alu_src_d = 1'b1; use_rd = 1'b1; imm_d = imm_u;
            end
            default: known_op = 1'b0;
        endcase
    end

    // Only indices the format actually uses can make an instruction illegal.
    logic reg_bad, illegal_d, legal_d;
    assign reg_bad   = (use_rs1 && idx_bad(ix[19:15])) ||
                       (use_rs2 && idx_bad(ix[24:20])) ||
                       (use_rd  && idx_bad(ix[11:7]));
    assign illegal_d = !known_op || reg_bad;
    assign legal_d   = !illegal_d;

    logic hazard_rs1, hazard_rs2;
    assign hazard_rs1 = use_rs1 && (ix[19:15] == wa);
    assign hazard_rs2 = use_rs2 && (ix[24:20] == wa);
    assign stall = if_valid && !flush && ex_valid && memRead && (wa != 5'd0) &&
                   (hazard_rs1 || hazard_rs2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            regWrite <= 1'b0;
            memToReg <= 1'b0;
            branch   <= 1'b0;
            jump     <= 1'b0;
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            aluSrc   <= 1'b0;
            aluOp    <= 2'b00;
            illegal  <= 1'b0;
            rd1      <= '0;
            rd2      <= '0;
            imm      <= '0;
            pc       <= '0;
            funct7_5 <= 1'b0;
            funct3   <= 3'b000;
            wa       <= 5'd0;
            rs1      <= 5'd0;
            rs2      <= 5'd0;
        end else begin
            rd1      <= rs_val[0];
            rd2      <= rs_val[1];
            imm      <= imm_d;
            pc       <= pc_in;
            funct7_5 <= ix[30];
            funct3   <= ix[14:12];
            wa       <= ix[11:7];
            rs1      <= ix[19:15];
            rs2      <= ix[24:20];
            if (flush || stall || !if_valid) begin
                ex_valid <= 1'b0;
                regWrite <= 1'b0;
                memToReg <= 1'b0;
                branch   <= 1'b0;
                jump     <= 1'b0;
                memRead  <= 1'b0;
                memWrite <= 1'b0;
                aluSrc   <= 1'b0;
                aluOp    <= 2'b00;
                illegal  <= 1'b0;
            end else begin
                ex_valid <= 1'b1;
                regWrite <= reg_write_d  && legal_d;
                memToReg <= mem_to_reg_d && legal_d;
                branch   <= branch_d     && legal_d;
                jump     <= jump_d       && legal_d;
                memRead  <= mem_read_d   && legal_d;
                memWrite <= mem_write_d  && legal_d;
                aluSrc   <= alu_src_d    && legal_d;
                aluOp    <= legal_d ? alu_op_d : 2'b00;
                illegal  <= illegal_d;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV64I instance and an RV32E-sized
// instance share stimulus and are checked against a format-level model.
module tb_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_valid, flush, wb_we;
    logic [31:0] ix;
    logic [63:0] pc_in, wb_wd;
    logic [4:0]  wb_wa;

    logic        stall_a, ex_valid_a, regWrite_a, memToReg_a, branch_a, jump_a;
    logic        memRead_a, memWrite_a, aluSrc_a, funct7_5_a, illegal_a;
    logic [1:0]  aluOp_a;
    logic [63:0] rd1_a, rd2_a, imm_a, pc_a;
    logic [2:0]  funct3_a;
    logic [4:0]  wa_a, rs1_a, rs2_a;

    logic        stall_b, ex_valid_b, regWrite_b, memToReg_b, branch_b, jump_b;
    logic        memRead_b, memWrite_b, aluSrc_b, funct7_5_b, illegal_b;
    logic [1:0]  aluOp_b;
    logic [31:0] rd1_b, rd2_b, imm_b, pc_b;
    logic [2:0]  funct3_b;
    logic [4:0]  wa_b, rs1_b, rs2_b;

    decode_stage #(.XLEN(64), .NREG(32)) dut_a (
        .clk(clk), .rst(rst), .if_valid(if_valid), .ix(ix), .pc_in(pc_in), .flush(flush),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .stall(stall_a), .ex_valid(ex_valid_a),
        .regWrite(regWrite_a), .memToReg(memToReg_a), .branch(branch_a), .jump(jump_a),
        .memRead(memRead_a), .memWrite(memWrite_a), .aluSrc(aluSrc_a), .aluOp(aluOp_a),
        .rd1(rd1_a), .rd2(rd2_a), .imm(imm_a), .pc(pc_a), .funct7_5(funct7_5_a),
        .funct3(funct3_a), .wa(wa_a), .rs1(rs1_a), .rs2(rs2_a), .illegal(illegal_a)
    );

    decode_stage #(.XLEN(32), .NREG(16)) dut_b (
        .clk(clk), .rst(rst), .if_valid(if_valid), .ix(ix), .pc_in(pc_in[31:0]), .flush(flush),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd[31:0]), .stall(stall_b), .ex_valid(ex_valid_b),
        .regWrite(regWrite_b), .memToReg(memToReg_b), .branch(branch_b), .jump(jump_b),
        .memRead(memRead_b), .memWrite(memWrite_b), .aluSrc(aluSrc_b), .aluOp(aluOp_b),
        .rd1(rd1_b), .rd2(rd2_b), .imm(imm_b), .pc(pc_b), .funct7_5(funct7_5_b),
        .funct3(funct3_b), .wa(wa_b), .rs1(rs1_b), .rs2(rs2_b), .illegal(illegal_b)
    );

    // ctrl = {regWrite, memToReg, branch, jump, memRead, memWrite, aluSrc, aluOp[1:0]}
    typedef struct packed {
        logic        full;
        logic        valid;
        logic        cmp1;
        logic        cmp2;
        logic [8:0]  ctrl;
        logic        illegal;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        f7;
        logic [2:0]  f3;
        logic [4:0]  wa;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    typedef enum int {F_R, F_I, F_S, F_B, F_U, F_J, F_X} fmt_e;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        cur [2];
    logic [63:0] rf [2][32];
    exp_t        act_a, act_b;
    int          checks = 0;
    int          errors = 0;
    logic        rst_seen = 1'b0;
    logic        last_stall = 1'b0;

    always_comb begin
        act_a = '0;
        act_a.valid = ex_valid_a;
        act_a.ctrl = {regWrite_a, memToReg_a, branch_a, jump_a, memRead_a, memWrite_a, aluSrc_a, aluOp_a};
        act_a.illegal = illegal_a;
        act_a.rd1 = rd1_a; act_a.rd2 = rd2_a; act_a.imm = imm_a; act_a.pc = pc_a;
        act_a.f7 = funct7_5_a; act_a.f3 = funct3_a;
        act_a.wa = wa_a; act_a.rs1 = rs1_a; act_a.rs2 = rs2_a;
        act_b = '0;
        act_b.valid = ex_valid_b;
        act_b.ctrl = {regWrite_b, memToReg_b, branch_b, jump_b, memRead_b, memWrite_b, aluSrc_b, aluOp_b};
        act_b.illegal = illegal_b;
        act_b.rd1 = {32'b0, rd1_b}; act_b.rd2 = {32'b0, rd2_b};
        act_b.imm = {32'b0, imm_b}; act_b.pc = {32'b0, pc_b};
        act_b.f7 = funct7_5_b; act_b.f3 = funct3_b;
        act_b.wa = wa_b; act_b.rs1 = rs1_b; act_b.rs2 = rs2_b;
    end

    function automatic int nreg_of(input int c);
        return (c == 0) ? 32 : 16;
    endfunction

    function automatic logic [63:0] mask(input int c, input logic [63:0] v);
        return (c == 0) ? v : {32'b0, v[31:0]};
    endfunction

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            7'b0110011:                         return F_R;
            7'b0010011, 7'b0000011, 7'b1100111: return F_I;
            7'b0100011:                         return F_S;
            7'b1100011:                         return F_B;
            7'b0110111, 7'b0010111:             return F_U;
            7'b1101111:                         return F_J;
            default:                            return F_X;
        endcase
    endfunction

    function automatic logic [8:0] ctrl_of(input logic [6:0] op);
        case (op)
            7'b0110011:             return 9'b1000000_10;
            7'b0010011:             return 9'b1000001_11;
            7'b0000011:             return 9'b1100101_00;
            7'b0100011:             return 9'b0000011_00;
            7'b1100011:             return 9'b0010000_01;
            7'b1101111:             return 9'b1001000_00;
            7'b1100111:             return 9'b1001001_00;
            7'b0110111, 7'b0010111: return 9'b1000001_00;
            default:                return 9'b0;
        endcase
    endfunction

    function automatic logic [63:0] imm_of(input logic [31:0] x, input fmt_e f);
        case (f)
            F_I:     return 64'($signed(x[31:20]));
            F_S:     return 64'($signed({x[31:25], x[11:7]}));
            F_B:     return 64'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            F_U:     return 64'($signed({x[31:12], 12'b0}));
            F_J:     return 64'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] read_model(input int c, input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (wb_we && wb_wa == idx) return mask(c, wb_wd);
        return rf[c][idx];
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [11:0] im);
        return {im, s1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                          input logic [11:0] im);
        return {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                          input logic [12:0] im);
        return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [12];
        logic [31:0] x;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'h7F, 7'b0000011};
        x = $urandom;
        if ($urandom_range(0, 15) != 0) x[6:0] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) != 0) begin
            x[19:15] = 5'($urandom_range(0, 7));
            x[24:20] = 5'($urandom_range(0, 7));
            x[11:7]  = 5'($urandom_range(0, 7));
        end
        return x;
    endfunction

    task automatic cmp(input string t, input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", t, n, act, exp);
        end
    endtask

    task automatic check_one(input string t, input exp_t e, input exp_t a);
        cmp(t, "ex_valid", 64'(a.valid), 64'(e.valid));
        cmp(t, "ctrl", 64'(a.ctrl), 64'(e.ctrl));
        cmp(t, "illegal", 64'(a.illegal), 64'(e.illegal));
        if (e.full) begin
            if (e.cmp1) cmp(t, "rd1", a.rd1, e.rd1);
            if (e.cmp2) cmp(t, "rd2", a.rd2, e.rd2);
            cmp(t, "imm", a.imm, e.imm);
            cmp(t, "pc", a.pc, e.pc);
            cmp(t, "funct7_5", 64'(a.f7), 64'(e.f7));
            cmp(t, "funct3", 64'(a.f3), 64'(e.f3));
            cmp(t, "wa", 64'(a.wa), 64'(e.wa));
            cmp(t, "rs1", 64'(a.rs1), 64'(e.rs1));
            cmp(t, "rs2", 64'(a.rs2), 64'(e.rs2));
        end
        if (e.valid)
            $display("txn %s pc=%h wa=%0d rs1=%0d rs2=%0d ctrl=%b illegal=%b imm=%h",
                     t, e.pc, e.wa, e.rs1, e.rs2, e.ctrl, e.illegal, e.imm);
    endtask

    // Monitor: one expected ID/EX state per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) check_one("A", q_a.pop_front(), act_a);
            if (q_b.size() > 0) check_one("B", q_b.pop_front(), act_b);
        end
    end

    // Drive one cycle, check stall, then predict the ID/EX state after the next edge.
    task automatic step(input logic r, input logic ifv, input logic fl, input logic [31:0] ins,
                        input logic we, input logic [4:0] wa, input logic [63:0] wd);
        exp_t e;
        fmt_e f;
        logic u1, u2, ud, st, bad;
        int   nr;
        @(negedge clk);
        rst = r; if_valid = ifv; flush = fl; ix = ins;
        pc_in = {$urandom, $urandom};
        wb_we = we; wb_wa = wa; wb_wd = wd;
        #1;
        f  = fmt_of(ins[6:0]);
        u1 = (f == F_R) || (f == F_I) || (f == F_S) || (f == F_B);
        u2 = (f == F_R) || (f == F_S) || (f == F_B);
        ud = (f == F_R) || (f == F_I) || (f == F_U) || (f == F_J);
        for (int c = 0; c < 2; c++) begin
            nr = nreg_of(c);
            st = ifv && !fl && cur[c].valid && cur[c].ctrl[4] && (cur[c].wa != 5'd0) &&
                 ((u1 && ins[19:15] == cur[c].wa) || (u2 && ins[24:20] == cur[c].wa));
            if (rst_seen) cmp((c == 0) ? "A" : "B", "stall", 64'((c == 0) ? stall_a : stall_b), 64'(st));
            if (c == 0) last_stall = st;
            e = '0;
            if (!r) begin
                e.full = 1'b1; e.cmp1 = 1'b1; e.cmp2 = 1'b1;
            end else if (!(fl || st || !ifv)) begin
                bad = (u1 && int'(ins[19:15]) >= nr) || (u2 && int'(ins[24:20]) >= nr) ||
                      (ud && int'(ins[11:7]) >= nr);
                e.full    = 1'b1;
                e.valid   = 1'b1;
                e.illegal = (f == F_X) || bad;
                e.ctrl    = e.illegal ? 9'b0 : ctrl_of(ins[6:0]);
                e.cmp1    = int'(ins[19:15]) < nr;
                e.cmp2    = int'(ins[24:20]) < nr;
                e.rd1     = read_model(c, ins[19:15]);
                e.rd2     = read_model(c, ins[24:20]);
                e.imm     = mask(c, imm_of(ins, f));
                e.pc      = mask(c, pc_in);
                e.f7 = ins[30]; e.f3 = ins[14:12];
                e.wa = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
            end
            if (c == 0) q_a.push_back(e); else q_b.push_back(e);
            cur[c] = e;
            if (!r) begin
                for (int i = 0; i < 32; i++) rf[c][i] = 64'd0;
            end else if (we && wa != 5'd0 && int'(wa) < nr) begin
                rf[c][wa] = mask(c, wd);
            end
        end
        if (!r) rst_seen = 1'b1;
    endtask

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [6:0]  LOAD = 7'b0000011;

    initial begin
        logic [31:0] ins, hold_ix;
        logic        v, fl, r;
        logic [4:0]  wa;
        rst = 1'b0; if_valid = 1'b0; flush = 1'b0; ix = NOP; pc_in = '0;
        wb_we = 1'b0; wb_wa = 5'd0; wb_wd = '0;
        step(1'b0, 1'b0, 1'b0, NOP, 1'b0, 5'd0, 64'd0);
        step(1'b0, 1'b0, 1'b0, NOP, 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, NOP, 1'b1, 5'd5, 64'h1234);
        step(1'b1, 1'b1, 1'b0, enc_r(5'd1, 5'd5, 5'd5), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, enc_i(LOAD, 5'd3, 5'd2, 3'b010, 12'hFFC), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, enc_r(5'd4, 5'd3, 5'd1), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, enc_r(5'd4, 5'd3, 5'd1), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, enc_s(5'd0, 5'd7, 3'b010, 12'd8), 1'b1, 5'd7, 64'hFFFF_0000);
        step(1'b1, 1'b1, 1'b0, enc_b(5'd0, 5'd0, 3'b000, 13'h1FFE), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, {20'h80000, 5'd1, 7'b0110111}, 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, enc_i(LOAD, 5'd3, 5'd2, 3'b010, 12'hFFC), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b1, enc_r(5'd4, 5'd3, 5'd1), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0000_007F, 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, enc_r(5'd17, 5'd1, 5'd2), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, NOP, 1'b1, 5'd0, 64'hAA);
        step(1'b1, 1'b1, 1'b0, enc_r(5'd1, 5'd0, 5'd0), 1'b1, 5'd0, 64'hAA);
        step(1'b1, 1'b1, 1'b0, enc_i(LOAD, 5'd3, 5'd2, 3'b010, 12'h004), 1'b0, 5'd0, 64'd0);
        step(1'b0, 1'b1, 1'b0, enc_r(5'd4, 5'd3, 5'd1), 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b1, 1'b0, enc_r(5'd4, 5'd3, 5'd1), 1'b0, 5'd0, 64'd0);

        hold_ix = NOP;
        for (int n = 0; n < 1200; n++) begin
            if (last_stall) begin
                ins = hold_ix; v = 1'b1;
            end else begin
                ins = rand_ins(); v = ($urandom_range(0, 9) != 0);
            end
            fl = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 199) != 0);
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step(r, v, fl, ins, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom});
            hold_ix = ins;
        end

        repeat (3) @(posedge clk);
        #2;
        cmp("A", "drain", 64'(q_a.size()), 64'd0);
        cmp("B", "drain", 64'(q_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
